instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the ID pipeline register and drives the core's 32-bit instruction input. It keeps the fetch PC, issues in-order word reads to instruction memory, and buffers returned instructions in a small FIFO. When no instruction is available, or the core stalls, it presents a canonical NOP. A redirect input flushes buffered and in-flight fetches for future branch and jump support.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Core-wide constants shared by fetch and the core's bubble insertion.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO; flush empties it and wins over a same-cycle push.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok = pop && !empty;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= inc(wr_ptr);
      if (pop_ok) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, request throttling against FIFO space, stale-response drop
// after redirect, and NOP insertion when nothing is buffered.
module instr_fetch import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc, tail_pc;
  logic [CW-1:0]   outstanding, drop, occ;
  logic            full, empty, pop, push, accept;
  int              inflight;
  fetch_entry_t    head, tail_entry;

  assign pop      = !empty && !stall && !redirect;
  assign inflight = int'(occ) + int'(outstanding) - int'(pop);
  // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
  assign imem_req = !rst && !redirect && (inflight < DEPTH);
  assign accept   = imem_req && imem_ready;
  assign push     = imem_rvalid && !redirect && (drop == '0);
  assign imem_addr = fetch_pc;

  assign tail_entry = '{pc: tail_pc, instr: imem_rdata};

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !full),
    .din   (tail_entry),
    .pop   (pop),
    .flush (redirect),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  assign instr_valid = !empty;
  assign instr       = empty ? NOP_INSTR : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      tail_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= redirect_pc;
        tail_pc  <= redirect_pc;
        // Everything still in flight belongs to the old stream.
        drop     <= outstanding - CW'(imem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   tail_pc  <= tail_pc + 32'd4;
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based memory and stream model plus directed phases.
module tb_instr_fetch;
  import riscv_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, imem_rvalid, stall, redirect, instr_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc));

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .instr(w_instr), .instr_valid(w_valid), .instr_pc(w_pc));

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  // 1-cycle memory for the wrap-around instance
  always @(posedge clk) begin
    w_rvalid <= !rst && w_req;
    w_rdata  <= mdata(w_addr);
  end

  typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
  mreq_t       memq[$];
  int          cyc, lat, epoch, buffered, checks, failures;
  logic [31:0] m_fetch, m_exp, held;
  logic        s_req, s_valid, sw_valid;
  logic [31:0] s_addr, s_pc, s_instr, sw_addr, sw_pc, sw_instr;
  logic [31:0] pc_tab [13];
  logic [31:0] wa_tab [5];
  logic [31:0] wp_tab [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic  pop_m, resp;
    mreq_t h;
    resp = !rst && memq.size() > 0 && memq[0].due <= cyc;
    imem_rvalid = resp;
    imem_rdata  = resp ? mdata(memq[0].addr) : 32'h0;
    #4;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc; s_instr = instr;
    sw_addr = w_addr; sw_valid = w_valid; sw_pc = w_pc; sw_instr = w_instr;
    pop_m = buffered > 0 && !stall && !redirect;
    if (rst) chk("req_in_reset", 32'(imem_req), 0);
    else begin
      chk("req", 32'(imem_req),
          32'(!redirect && (buffered + memq.size() - int'(pop_m)) < DEPTH));
      chk("addr", imem_addr, m_fetch);
      chk("valid", 32'(instr_valid), 32'(buffered > 0));
      chk("instr_pc", instr_pc, buffered > 0 ? m_exp : 32'h0);
      chk("instr", instr, buffered > 0 ? mdata(m_exp) : NOP_INSTR);
      chk("inflight_bound", 32'(buffered + memq.size() <= DEPTH), 1);
      chk("overflow", 32'(dut.push && dut.full), 0);
    end
    @(posedge clk);
    if (rst) begin
      memq.delete(); buffered = 0; m_fetch = 0; m_exp = 0; epoch++;
    end else begin
      if (resp) begin
        h = memq.pop_front();
        if (h.ep == epoch && !redirect) buffered++;
      end
      if (s_req && imem_ready) memq.push_back('{s_addr, cyc + lat, epoch});
      if (pop_m) begin buffered--; m_exp += 4; end
      if (redirect) begin
        epoch++; buffered = 0; m_fetch = redirect_pc; m_exp = redirect_pc;
      end else if (s_req && imem_ready) m_fetch += 4;
    end
    cyc++;
    #1;
  endtask

  task automatic wrap_chk(input int k);
    chk("wrap_addr", sw_addr, wa_tab[k]);
    chk("wrap_valid", 32'(sw_valid), 32'(k >= 2));
    if (k >= 2) begin
      chk("wrap_pc", sw_pc, wp_tab[k]);
      chk("wrap_instr", sw_instr, mdata(wp_tab[k]));
    end
  endtask

  initial begin
    pc_tab = '{0, 0, 0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'h10, 32'h14, 32'h18};
    wa_tab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    wp_tab = '{0, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    checks = 0; failures = 0; cyc = 0; epoch = 0; buffered = 0; lat = 1;
    m_fetch = 0; m_exp = 0; held = 0;
    rst = 1; imem_ready = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_rvalid = 0; imem_rdata = 0;
    step(); step();
    rst = 0;

    // Phase A: 1-cycle memory, stall over cycles 5..8
    for (int k = 0; k < 13; k++) begin
      stall = (k >= 5 && k <= 8);
      step();
      if (k <= 4) chk("a_addr", s_addr, 32'(4 * k));
      if (k == 9) chk("a_addr_resume", s_addr, 32'h14);
      if (k == 10) chk("a_addr_next", s_addr, 32'h18);
      if (k == 6 || k == 8) chk("a_req_full", 32'(s_req), 0);
      chk("a_valid", 32'(s_valid), 32'(k >= 2));
      if (k >= 2) chk("a_pc", s_pc, pc_tab[k]);
      if (k <= 4) wrap_chk(k);
    end
    stall = 0;

    // Phase B: 3-cycle memory with ready low for three cycles
    lat = 3;
    for (int k = 0; k < 15; k++) begin
      imem_ready = !(k >= 2 && k <= 4);
      stall = (k == 9 || k == 10);
      step();
      if (k == 2) held = s_addr;
      if (k == 3 || k == 4) chk("b_hold_addr", s_addr, held);
    end
    imem_ready = 1; stall = 0;

    // Phase C: redirect with two requests outstanding
    for (int n = 0; n < 20 && memq.size() != 2; n++) step();
    chk("c_two_outstanding", 32'(memq.size()), 2);
    redirect = 1; redirect_pc = 32'h100;
    step();
    chk("c_no_req_on_redirect", 32'(s_req), 0);
    redirect = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (s_valid) break;
    end
    chk("c_first_valid", 32'(s_valid), 1);
    chk("c_first_pc", s_pc, 32'h100);

    // Phase D: redirect coinciding with stall and a returning response
    for (int n = 0; n < 20 && !(memq.size() > 0 && memq[0].due <= cyc && buffered > 0); n++)
      step();
    chk("d_setup", 32'(memq.size() > 0 && memq[0].due <= cyc && buffered > 0), 1);
    stall = 1; redirect = 1; redirect_pc = 32'h200;
    step();
    redirect = 0; stall = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (s_valid) break;
    end
    chk("d_first_pc", s_pc, 32'h200);
    for (int k = 0; k < 12; k++) begin
      stall = (k % 3 == 0);
      step();
    end

    // Phase E: reset with a full FIFO
    lat = 1; stall = 1;
    for (int n = 0; n < 20 && buffered != 2; n++) step();
    chk("e_fifo_full", 32'(buffered), 2);
    rst = 1;
    step();
    rst = 0; stall = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 0) begin
        chk("e_instr_nop", s_instr, 32'h0000_0013);
        chk("e_valid_low", 32'(s_valid), 0);
        chk("e_addr_reset", s_addr, 32'h0);
      end
      if (k == 2) chk("e_restart_pc", s_pc, 32'h0);
      if (k <= 4) wrap_chk(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
